// File: rtl/systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_tile_sequencer
//
// Control FSM for one tiled matrix multiply on a SYS_ROWS x SYS_COLS
// weight-stationary systolic array. Each (n,k) tile follows three phases:
//   LOAD_W : preload SYS_ROWS weight rows from the weight buffer
//   STREAM : stream A_ROWS activation rows from the input buffer
//   DRAIN  : wait ARRAY_LAT cycles so the last array output row can land
// Accumulator writes are the input-buffer read strobe delayed by ARRAY_LAT.
// K tiles accumulate into the same output rows. N tiles write separate
// output blocks.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request to begin a full run (honoured in IDLE only)
//   busy            high in LOAD_W, STREAM and DRAIN
//   done            one-cycle pulse at the end of the run
//   w_rd_en/addr    weight buffer read strobe and address
//   w_load          array weight shift-in (w_rd_en delayed by one cycle)
//   in_rd_en/addr   input buffer read strobe and address
//   acc_wr_en/addr  accumulator write strobe and row address
//   acc_accumulate  1 = add to the stored row, 0 = overwrite
//   cycle_count     busy-cycle counter (only when SEQ_PERF_CNT_EN is defined)
//
// Optional feature macro: SEQ_PERF_CNT_EN
// -----------------------------------------------------------------------------
module systolic_tile_sequencer #(
  parameter int unsigned SYS_ROWS  = 8,
  parameter int unsigned SYS_COLS  = 8,
  parameter int unsigned A_ROWS    = 12,
  parameter int unsigned K_TILES   = 1,
  parameter int unsigned N_TILES   = 1,
  parameter int unsigned ARRAY_LAT = 16,
  parameter int unsigned W_AW      = 4,
  parameter int unsigned IN_AW     = 4,
  parameter int unsigned ACC_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_rd_addr,
  output logic              w_load,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_rd_addr,
  output logic              acc_wr_en,
  output logic [ACC_AW-1:0] acc_wr_addr,
  output logic              acc_accumulate
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  // Phase counter must hold the longest phase length minus one.
  localparam int unsigned CNT_MAX = (SYS_ROWS > A_ROWS)
                                    ? ((SYS_ROWS > ARRAY_LAT) ? SYS_ROWS : ARRAY_LAT)
                                    : ((A_ROWS > ARRAY_LAT) ? A_ROWS : ARRAY_LAT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned K_W     = $clog2(K_TILES + 1);
  localparam int unsigned N_W     = $clog2(N_TILES + 1);

  // Elaboration-time parameter checks: a too-narrow address port is a
  // configuration error and must not wrap silently.
  if (SYS_ROWS < 1 || SYS_COLS < 1 || A_ROWS < 1 || ARRAY_LAT < 1 ||
      K_TILES < 1 || N_TILES < 1) begin : g_dim_err
    $error("systolic_tile_sequencer: all dimensions must be at least 1");
  end
  if (64'(N_TILES) * K_TILES * SYS_ROWS > (64'd1 << W_AW)) begin : g_w_aw_err
    $error("systolic_tile_sequencer: W_AW too narrow for weight addresses");
  end
  if (64'(K_TILES) * A_ROWS > (64'd1 << IN_AW)) begin : g_in_aw_err
    $error("systolic_tile_sequencer: IN_AW too narrow for input addresses");
  end
  if (64'(N_TILES) * A_ROWS > (64'd1 << ACC_AW)) begin : g_acc_aw_err
    $error("systolic_tile_sequencer: ACC_AW too narrow for accumulator addresses");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [K_W-1:0]     k_idx;
  logic [N_W-1:0]     n_idx;
  logic               phase_last;
  logic               k_last;
  logic               n_last;
  logic               accept;

  assign k_last = (k_idx == K_W'(K_TILES - 1));
  assign n_last = (n_idx == N_W'(N_TILES - 1));
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    w_rd_en    = 1'b0;
    in_rd_en   = 1'b0;
    phase_last = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        busy       = 1'b1;
        w_rd_en    = 1'b1;
        phase_last = (cnt == CNT_W'(SYS_ROWS - 1));
        if (phase_last) state_nxt = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        in_rd_en   = 1'b1;
        phase_last = (cnt == CNT_W'(A_ROWS - 1));
        if (phase_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        phase_last = (cnt == CNT_W'(ARRAY_LAT - 1));
        if (phase_last) state_nxt = (k_last && n_last) ? DONE : LOAD_W;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase row counter and tile indices; k runs fastest so all K partial
  // sums of one output block are accumulated before moving to the next n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      k_idx <= '0;
      n_idx <= '0;
    end else begin
      cnt <= (busy && !phase_last) ? cnt + CNT_W'(1) : '0;
      if (accept) begin
        k_idx <= '0;
        n_idx <= '0;
      end else if (state == DRAIN && phase_last) begin
        if (!k_last) begin
          k_idx <= k_idx + K_W'(1);
        end else if (!n_last) begin
          k_idx <= '0;
          n_idx <= n_idx + N_W'(1);
        end
      end
    end
  end

  // Addresses are computed at 32 bits and truncated; the checks above
  // guarantee the truncation never drops a set bit. They are forced to 0
  // when their strobe is low so idle buses stay quiet.
  assign w_rd_addr  = w_rd_en
                      ? W_AW'((32'(n_idx) * K_TILES + 32'(k_idx)) * SYS_ROWS + 32'(cnt))
                      : '0;
  assign in_rd_addr = in_rd_en
                      ? IN_AW'(32'(k_idx) * A_ROWS + 32'(cnt))
                      : '0;

  // Stage p0: weight buffer read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_load <= 1'b0;
    end else begin
      w_load <= w_rd_en;
    end
  end

  // Accumulator write delay line: entry 0 captures the current input read,
  // entry ARRAY_LAT-1 drives the accumulator. Cleared by reset so nothing
  // in flight survives an abort.
  logic              acc_vld_pipe   [ARRAY_LAT];
  logic [ACC_AW-1:0] acc_addr_pipe  [ARRAY_LAT];
  logic              acc_accum_pipe [ARRAY_LAT];
  logic [ACC_AW-1:0] acc_addr_p0;
  logic              acc_accum_p0;

  assign acc_addr_p0  = in_rd_en ? ACC_AW'(32'(n_idx) * A_ROWS + 32'(cnt)) : '0;
  assign acc_accum_p0 = in_rd_en && (k_idx != '0);

  // Stage p0..pLAT-1: array latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARRAY_LAT; i++) begin
        acc_vld_pipe[i]   <= 1'b0;
        acc_addr_pipe[i]  <= '0;
        acc_accum_pipe[i] <= 1'b0;
      end
    end else begin
      acc_vld_pipe[0]   <= in_rd_en;
      acc_addr_pipe[0]  <= acc_addr_p0;
      acc_accum_pipe[0] <= acc_accum_p0;
      for (int i = 1; i < ARRAY_LAT; i++) begin
        acc_vld_pipe[i]   <= acc_vld_pipe[i-1];
        acc_addr_pipe[i]  <= acc_addr_pipe[i-1];
        acc_accum_pipe[i] <= acc_accum_pipe[i-1];
      end
    end
  end

  assign acc_wr_en      = acc_vld_pipe[ARRAY_LAT-1];
  assign acc_wr_addr    = acc_addr_pipe[ARRAY_LAT-1];
  assign acc_accumulate = acc_accum_pipe[ARRAY_LAT-1];

`ifdef SEQ_PERF_CNT_EN
  // Counts busy cycles of the current run; holds after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (accept) begin
      cycle_count <= '0;
    end else if (busy) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_sequencer
//
// Three sequencer instances share clk/rst/start:
//   u0 defaults, u1 K_TILES=2 (IN_AW=5), u2 N_TILES=2 (ACC_AW=5).
// A closed-form model gives every output as a function of the number of
// cycles since the accepted start; one compare process checks all outputs
// of all instances every cycle, and also checks hand-computed totals.
// -----------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

  localparam int SR  = 8;
  localparam int AR  = 12;
  localparam int LAT = 16;

  int KT [3] = '{1, 2, 1};
  int NT [3] = '{1, 1, 2};

  logic clk;
  logic rst;
  logic start;

  logic       busy_s  [3];
  logic       done_s  [3];
  logic       wen_s   [3];
  logic       wload_s [3];
  logic       inen_s  [3];
  logic       accen_s [3];
  logic       accum_s [3];
  logic [3:0] w_addr0, w_addr1, w_addr2;
  logic [3:0] in_addr0, in_addr2;
  logic [4:0] in_addr1;
  logic [3:0] acc_addr0, acc_addr1;
  logic [4:0] acc_addr2;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cc0, cc1, cc2;
`endif

  systolic_tile_sequencer u0 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy_s[0]), .done(done_s[0]),
    .w_rd_en(wen_s[0]), .w_rd_addr(w_addr0), .w_load(wload_s[0]),
    .in_rd_en(inen_s[0]), .in_rd_addr(in_addr0),
    .acc_wr_en(accen_s[0]), .acc_wr_addr(acc_addr0), .acc_accumulate(accum_s[0])
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cc0)
`endif
  );

  systolic_tile_sequencer #(.K_TILES(2), .IN_AW(5)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy_s[1]), .done(done_s[1]),
    .w_rd_en(wen_s[1]), .w_rd_addr(w_addr1), .w_load(wload_s[1]),
    .in_rd_en(inen_s[1]), .in_rd_addr(in_addr1),
    .acc_wr_en(accen_s[1]), .acc_wr_addr(acc_addr1), .acc_accumulate(accum_s[1])
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cc1)
`endif
  );

  systolic_tile_sequencer #(.N_TILES(2), .ACC_AW(5)) u2 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy_s[2]), .done(done_s[2]),
    .w_rd_en(wen_s[2]), .w_rd_addr(w_addr2), .w_load(wload_s[2]),
    .in_rd_en(inen_s[2]), .in_rd_addr(in_addr2),
    .acc_wr_en(accen_s[2]), .acc_wr_addr(acc_addr2), .acc_accumulate(accum_s[2])
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  int run_t [3];   // 0 = idle, t = t-th cycle after the accepted start
  int cyc;

  function automatic int total_of(input int i);
    return KT[i] * NT[i] * (SR + AR + LAT);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) run_t[i] <= 0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
        if (run_t[i] == 0) begin
          if (start) run_t[i] <= 1;
        end else if (run_t[i] == total_of(i) + 1) begin
          run_t[i] <= 0;
        end else begin
          run_t[i] <= run_t[i] + 1;
        end
      end
    end
  end

  // e: 0 busy,1 done,2 w_rd_en,3 w_rd_addr,4 w_load,5 in_rd_en,6 in_rd_addr,
  //    7 acc_wr_en,8 acc_wr_addr,9 acc_accumulate
  function automatic void model(input int i, input int t, output int e [10]);
    int tile, total, ti, o, k, n;
    tile  = SR + AR + LAT;
    total = total_of(i);
    for (int s = 0; s < 10; s++) e[s] = 0;
    if (t >= 1 && t <= total) begin
      e[0] = 1;
      ti = (t - 1) / tile;
      o  = (t - 1) % tile;
      n  = ti / KT[i];
      k  = ti % KT[i];
      if (o < SR) begin
        e[2] = 1; e[3] = ti * SR + o;
      end else if (o < SR + AR) begin
        e[5] = 1; e[6] = k * AR + o - SR;
      end
      if (o >= SR + LAT && o < SR + AR + LAT) begin
        e[7] = 1; e[8] = n * AR + o - SR - LAT; e[9] = (k != 0) ? 1 : 0;
      end
    end
    if (t >= 2 && t - 1 <= total && ((t - 2) % tile) < SR) e[4] = 1;
    if (t == total + 1) e[1] = 1;
  endfunction

  // ---------------- checking ----------------
  int ncmp;
  int nfail;
  int chk_req;
  int a_start, b_start, d_start;
  int done_cnt [3];
  int done_cyc [3];
  int acc_cnt  [3];
  int accum_cnt[3];
  int max_w    [3];
  int max_in   [3];
  int max_acc  [3];
  string nm [10] = '{"busy", "done", "w_rd_en", "w_rd_addr", "w_load",
                     "in_rd_en", "in_rd_addr", "acc_wr_en", "acc_wr_addr",
                     "acc_accumulate"};

  task automatic chk(input string name, input int inst, input int got, input int want);
    ncmp++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s inst%0d cyc=%0d got %0d want %0d", name, inst, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int e [10];
      int a [10];
      model(i, run_t[i], e);
      a[0] = int'(busy_s[i]);
      a[1] = int'(done_s[i]);
      a[2] = int'(wen_s[i]);
      a[4] = int'(wload_s[i]);
      a[5] = int'(inen_s[i]);
      a[7] = int'(accen_s[i]);
      a[9] = int'(accum_s[i]);
      case (i)
        0: begin a[3] = int'(w_addr0); a[6] = int'(in_addr0); a[8] = int'(acc_addr0); end
        1: begin a[3] = int'(w_addr1); a[6] = int'(in_addr1); a[8] = int'(acc_addr1); end
        default: begin a[3] = int'(w_addr2); a[6] = int'(in_addr2); a[8] = int'(acc_addr2); end
      endcase
      for (int s = 0; s < 10; s++) chk(nm[s], i, a[s], e[s]);
      chk("rd_exclusive", i, a[2] & a[5], 0);
      if (a[1] != 0) begin done_cnt[i]++; done_cyc[i] = cyc; end
      if (a[2] != 0 && a[3] > max_w[i]) max_w[i] = a[3];
      if (a[5] != 0 && a[6] > max_in[i]) max_in[i] = a[6];
      if (a[7] != 0) begin
        acc_cnt[i]++;
        if (a[9] != 0) accum_cnt[i]++;
        if (a[8] > max_acc[i]) max_acc[i] = a[8];
      end
    end
`ifdef SEQ_PERF_CNT_EN
    if (done_s[0]) chk("cycle_count_at_done", 0, int'(cc0), 36);
`endif
    case (chk_req)
      1: begin
        chk("done_latency", 0, done_cyc[0] - a_start, 37);
        chk("done_latency", 1, done_cyc[1] - a_start, 73);
        chk("done_latency", 2, done_cyc[2] - a_start, 73);
        chk("done_pulses", 0, done_cnt[0], 1);
        chk("done_pulses", 1, done_cnt[1], 1);
        chk("done_pulses", 2, done_cnt[2], 1);
        chk("acc_writes", 0, acc_cnt[0], 12);
        chk("acc_writes", 1, acc_cnt[1], 24);
        chk("acc_writes", 2, acc_cnt[2], 24);
        chk("accumulate_writes", 0, accum_cnt[0], 0);
        chk("accumulate_writes", 1, accum_cnt[1], 12);
        chk("accumulate_writes", 2, accum_cnt[2], 0);
        chk("max_w_addr", 0, max_w[0], 7);
        chk("max_w_addr", 1, max_w[1], 15);
        chk("max_in_addr", 0, max_in[0], 11);
        chk("max_in_addr", 1, max_in[1], 23);
        chk("max_acc_addr", 1, max_acc[1], 11);
        chk("max_acc_addr", 2, max_acc[2], 23);
      end
      2: begin
        for (int i = 0; i < 3; i++) chk("done_pulses_held_start", i, done_cnt[i], 2);
        chk("done_latency_held_start", 0, done_cyc[0] - b_start, 37);
        chk("done_latency_held_start", 1, done_cyc[1] - b_start, 73);
        chk("acc_writes_held_start", 0, acc_cnt[0], 24);
      end
      3: begin
        chk("acc_writes_after_abort", 0, acc_cnt[0], 31);
        chk("acc_writes_after_abort", 1, acc_cnt[1], 55);
        chk("acc_writes_after_abort", 2, acc_cnt[2], 55);
        chk("done_pulses_after_abort", 0, done_cnt[0], 2);
      end
      4: begin
        chk("done_latency_restart", 0, done_cyc[0] - d_start, 37);
        chk("done_pulses_restart", 0, done_cnt[0], 3);
        chk("acc_writes_restart", 0, acc_cnt[0], 43);
        chk("acc_writes_restart", 1, acc_cnt[1], 79);
`ifdef SEQ_PERF_CNT_EN
        chk("cycle_count_held", 0, int'(cc0), 36);
`endif
      end
      default: ;
    endcase
  end

  task automatic request_check(input int code);
    chk_req = code;
    @(posedge clk);
    #1 chk_req = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    chk_req = 0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single start pulse
    a_start = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (80) @(posedge clk);
    #1 request_check(1);

    // start held through the whole short run, including its DONE cycle
    b_start = cyc;
    start = 1'b1;
    repeat (38) @(posedge clk);
    #1 start = 1'b0;
    repeat (80) @(posedge clk);
    #1 request_check(2);

    // abort during DRAIN with 5 accumulator writes still in flight
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (31) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 request_check(3);

    // clean restart after the abort
    d_start = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (90) @(posedge clk);
    #1 request_check(4);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
